// File: rtl/code_conv_pkg.sv
// Shared types and constants for the streaming code converter.
// Error checking in the top is enabled by defining CODE_CONV_ERR_CHECK_EN.
package code_conv_pkg;

    typedef enum logic [2:0] {
        OP_BIN2GRAY = 3'd0,
        OP_GRAY2BIN = 3'd1,
        OP_BIN2BCD  = 3'd2,
        OP_BCD2BIN  = 3'd3,
        OP_BCD2EX3  = 3'd4,
        OP_EX32BCD  = 3'd5,
        OP_BIN2EX3  = 3'd6,
        OP_RSVD     = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        OUT  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        ITER_DD_BCD = 2'd0,
        ITER_DD_EX3 = 2'd1,
        ITER_ACC    = 2'd2
    } iter_mode_e;

    localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
    localparam logic [3:0] EX3_OFFSET    = 4'd3;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/code_conv_iter_unit.sv
// Iterative engine: double-dabble (binary to BCD/excess-3) and BCD digit
// accumulation (BCD to binary). Loaded by start, signals its final step on last.
module code_conv_iter_unit
    import code_conv_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3,
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  iter_mode_e        mode,
    input  logic [DATA_W-1:0] operand,
    output logic              last,
    output logic [DATA_W-1:0] result,
    output logic              ovf
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int MAXIT = (WIDTH > DIGITS) ? WIDTH : DIGITS;
    localparam int IT_W  = clog2(MAXIT + 1);
    localparam logic [IT_W-1:0] DD_LAST  = IT_W'(WIDTH - 1);
    localparam logic [IT_W-1:0] ACC_LAST = IT_W'(DIGITS - 1);

    logic              run_r;
    iter_mode_e        mode_r;
    logic [IT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]  bin_r;
    logic [BCD_W-1:0]  bcd_r;
    logic [WIDTH-1:0]  acc_r;
    logic              ovf_r;

    logic [BCD_W-1:0]  adj_s;
    logic [BCD_W-1:0]  dd_next_s;
    logic [BCD_W-1:0]  ex3_s;
    logic [WIDTH+3:0]  acc_wide_s;
    logic [3:0]        digit_s;
    logic              ovf_next_s;

    // One iteration step; a carry out of the top BCD digit means the value no longer fits
    always_comb begin
        adj_s = bcd_r;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_r[4*i +: 4] > 4'd4) begin
                adj_s[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
            end else begin
                adj_s[4*i +: 4] = bcd_r[4*i +: 4];
            end
        end
        dd_next_s = {adj_s[BCD_W-2:0], bin_r[WIDTH-1]};
        ex3_s     = dd_next_s;
        for (int i = 0; i < DIGITS; i++) begin
            ex3_s[4*i +: 4] = dd_next_s[4*i +: 4] + EX3_OFFSET;
        end
        digit_s    = bcd_r[BCD_W-1 -: 4];
        acc_wide_s = {1'b0, acc_r, 3'b000} + {3'b000, acc_r, 1'b0} + {{WIDTH{1'b0}}, digit_s};
        if (mode_r == ITER_ACC) begin
            ovf_next_s = ovf_r | (|acc_wide_s[WIDTH+3:WIDTH]);
        end else begin
            ovf_next_s = ovf_r | adj_s[BCD_W-1];
        end
    end

    // Result view of the step currently being taken
    always_comb begin
        result = {DATA_W{1'b0}};
        case (mode_r)
            ITER_ACC:    result[WIDTH-1:0] = acc_wide_s[WIDTH-1:0];
            ITER_DD_EX3: result[BCD_W-1:0] = ex3_s;
            ITER_DD_BCD: result[BCD_W-1:0] = dd_next_s;
            default:     result[BCD_W-1:0] = dd_next_s;
        endcase
        if (run_r && (cnt_r == ((mode_r == ITER_ACC) ? ACC_LAST : DD_LAST))) begin
            last = 1'b1;
        end else begin
            last = 1'b0;
        end
    end

    assign ovf = ovf_next_s;

    // Iteration registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_r  <= 1'b0;
            mode_r <= ITER_DD_BCD;
            cnt_r  <= {IT_W{1'b0}};
            bin_r  <= {WIDTH{1'b0}};
            bcd_r  <= {BCD_W{1'b0}};
            acc_r  <= {WIDTH{1'b0}};
            ovf_r  <= 1'b0;
        end else if (start) begin
            run_r  <= 1'b1;
            mode_r <= mode;
            cnt_r  <= {IT_W{1'b0}};
            bin_r  <= operand[WIDTH-1:0];
            bcd_r  <= (mode == ITER_ACC) ? operand[BCD_W-1:0] : {BCD_W{1'b0}};
            acc_r  <= {WIDTH{1'b0}};
            ovf_r  <= 1'b0;
        end else if (run_r) begin
            cnt_r <= cnt_r + IT_W'(1'b1);
            ovf_r <= ovf_next_s;
            if (mode_r == ITER_ACC) begin
                acc_r <= acc_wide_s[WIDTH-1:0];
                bcd_r <= bcd_r << 3'd4;
            end else begin
                bin_r <= bin_r << 1'b1;
                bcd_r <= dd_next_s;
            end
            if (last) begin
                run_r <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/code_converter_stream.sv
// Streaming code converter with valid/ready request and result channels.
// Define CODE_CONV_ERR_CHECK_EN to drive m_err; otherwise m_err stays 0.
module code_converter_stream
    import code_conv_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3,
    parameter int TAG_W  = 4,
    parameter int CNT_W  = 16,
    localparam int DATA_W = (WIDTH > 4 * DIGITS) ? WIDTH : 4 * DIGITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [2:0]        s_op,
    input  logic [TAG_W-1:0]  s_tag,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [TAG_W-1:0]  m_tag,
    output logic              m_err,
    output logic              busy,
    output logic [CNT_W-1:0]  done_cnt
);

    localparam int BCD_W = 4 * DIGITS;
`ifdef CODE_CONV_ERR_CHECK_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    state_e            state_r, state_next_s;
    logic              s_ready_r, m_valid_r, busy_r, m_err_r, pre_err_r;
    logic [DATA_W-1:0] m_data_r;
    logic [TAG_W-1:0]  m_tag_r;
    logic [CNT_W-1:0]  done_cnt_r;

    op_e               op_s;
    logic              accept_s, handshake_s, to_conv_s, one_err_s;
    logic              bcd_bad_s, ex3_bad_s;
    logic [WIDTH-1:0]  bin_in_s, gray_s, gbin_s;
    logic [BCD_W-1:0]  bcd2ex3_s, ex32bcd_s;
    logic [DATA_W-1:0] one_data_s;
    iter_mode_e        iter_mode_s;
    logic              iter_last_s, iter_ovf_s;
    logic [DATA_W-1:0] iter_result_s;

    assign op_s        = op_e'(s_op);
    assign accept_s    = s_valid && s_ready_r;
    assign handshake_s = m_valid_r && m_ready;

    // Single-cycle conversions and digit validity on the raw operand
    always_comb begin
        logic [3:0] dig;
        dig       = 4'd0;
        bin_in_s  = s_data[WIDTH-1:0];
        gray_s    = bin_in_s ^ (bin_in_s >> 1'b1);
        gbin_s    = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            gbin_s[i] = ^(bin_in_s >> i);
        end
        bcd_bad_s = 1'b0;
        ex3_bad_s = 1'b0;
        bcd2ex3_s = {BCD_W{1'b0}};
        ex32bcd_s = {BCD_W{1'b0}};
        for (int d = 0; d < DIGITS; d++) begin
            dig = s_data[4*d +: 4];
            bcd_bad_s = bcd_bad_s | (dig > BCD_DIGIT_MAX);
            ex3_bad_s = ex3_bad_s | (dig < EX3_OFFSET) | (dig > 4'd12);
            bcd2ex3_s[4*d +: 4] = dig + EX3_OFFSET;
            ex32bcd_s[4*d +: 4] = dig - EX3_OFFSET;
        end
    end

    // Opcode routing: immediate result or hand-off to the iterative engine
    always_comb begin
        one_data_s  = {DATA_W{1'b0}};
        one_err_s   = 1'b0;
        to_conv_s   = 1'b0;
        iter_mode_s = ITER_DD_BCD;
        case (op_s)
            OP_BIN2GRAY: one_data_s[WIDTH-1:0] = gray_s;
            OP_GRAY2BIN: one_data_s[WIDTH-1:0] = gbin_s;
            OP_BCD2EX3: begin
                one_data_s[BCD_W-1:0] = bcd2ex3_s;
                one_err_s             = bcd_bad_s;
            end
            OP_EX32BCD: begin
                one_data_s[BCD_W-1:0] = ex32bcd_s;
                one_err_s             = ex3_bad_s;
            end
            OP_BIN2BCD: begin
                to_conv_s   = 1'b1;
                iter_mode_s = ITER_DD_BCD;
            end
            OP_BIN2EX3: begin
                to_conv_s   = 1'b1;
                iter_mode_s = ITER_DD_EX3;
            end
            OP_BCD2BIN: begin
                to_conv_s   = 1'b1;
                iter_mode_s = ITER_ACC;
            end
            default: one_err_s = 1'b1;
        endcase
    end

    code_conv_iter_unit #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS),
        .DATA_W (DATA_W)
    ) u_iter (
        .clk     (clk),
        .rst     (rst),
        .start   (accept_s && to_conv_s),
        .mode    (iter_mode_s),
        .operand (s_data),
        .last    (iter_last_s),
        .result  (iter_result_s),
        .ovf     (iter_ovf_s)
    );

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = to_conv_s ? CONV : OUT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CONV: begin
                if (iter_last_s) begin
                    state_next_s = OUT;
                end else begin
                    state_next_s = CONV;
                end
            end
            OUT: begin
                if (m_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = OUT;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State and registered handshake/status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            s_ready_r <= 1'b1;
            m_valid_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            s_ready_r <= (state_next_s == IDLE);
            m_valid_r <= (state_next_s == OUT);
            busy_r    <= (state_next_s != IDLE);
        end
    end

    // Result payload; held unchanged for the whole OUT phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data_r  <= {DATA_W{1'b0}};
            m_tag_r   <= {TAG_W{1'b0}};
            m_err_r   <= 1'b0;
            pre_err_r <= 1'b0;
        end else if (accept_s) begin
            m_tag_r   <= s_tag;
            pre_err_r <= ERR_EN & bcd_bad_s & (op_s == OP_BCD2BIN);
            if (!to_conv_s) begin
                m_data_r <= one_data_s;
                m_err_r  <= ERR_EN & one_err_s;
            end
        end else if ((state_r == CONV) && iter_last_s) begin
            m_data_r <= iter_result_s;
            m_err_r  <= ERR_EN & (pre_err_r | iter_ovf_s);
        end
    end

    // Saturating count of delivered results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_cnt_r <= {CNT_W{1'b0}};
        end else if (handshake_s && (done_cnt_r != {CNT_W{1'b1}})) begin
            done_cnt_r <= done_cnt_r + CNT_W'(1'b1);
        end
    end

    assign s_ready  = s_ready_r;
    assign m_valid  = m_valid_r;
    assign m_data   = m_data_r;
    assign m_tag    = m_tag_r;
    assign m_err    = m_err_r;
    assign busy     = busy_r;
    assign done_cnt = done_cnt_r;

endmodule

// File: tb/tb_code_converter_stream.sv
// Self-checking bench for code_converter_stream: directed vectors plus random
// requests checked against an arithmetic reference model.
module tb_code_converter_stream;

    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;
    localparam int TAG_W  = 4;
    localparam int CNT_W  = 16;
    localparam int DATA_W = 12;
`ifdef CODE_CONV_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              s_valid, s_ready;
    logic [2:0]        s_op;
    logic [TAG_W-1:0]  s_tag;
    logic [DATA_W-1:0] s_data;
    logic              m_valid, m_ready;
    logic [DATA_W-1:0] m_data;
    logic [TAG_W-1:0]  m_tag;
    logic              m_err, busy;
    logic [CNT_W-1:0]  done_cnt;

    int checks = 0;
    int failures = 0;
    logic [CNT_W-1:0] exp_cnt = '0;

    code_converter_stream #(
        .WIDTH(WIDTH), .DIGITS(DIGITS), .TAG_W(TAG_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_op(s_op),
        .s_tag(s_tag), .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_tag(m_tag), .m_err(m_err), .busy(busy), .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;

    // Reference model from the arithmetic definitions of each conversion
    function automatic void model(input logic [2:0] op, input logic [11:0] d,
                                  output logic [11:0] ed, output logic ee, output int el);
        int v, acc, dig;
        bit bad;
        ed = 12'h000; ee = 1'b0; el = 1; bad = 1'b0;
        case (op)
            3'd0: begin v = int'(d[7:0]); ed = 12'(v ^ (v >> 1)); end
            3'd1: begin
                for (int b = 0; b < 256; b++)
                    if (((b ^ (b >> 1)) & 255) == int'(d[7:0])) ed = 12'(b);
            end
            3'd2, 3'd6: begin
                v = int'(d[7:0]); el = 1 + WIDTH; ee = (v > 999);
                v = v % 1000;
                for (int k = 0; k < DIGITS; k++) begin
                    dig = v % 10 + ((op == 3'd6) ? 3 : 0);
                    v = v / 10;
                    ed = ed | 12'(dig << (4 * k));
                end
            end
            3'd3: begin
                acc = 0; el = 1 + DIGITS;
                for (int k = DIGITS - 1; k >= 0; k--) begin
                    dig = (int'(d) >> (4 * k)) & 15;
                    if (dig > 9) bad = 1'b1;
                    acc = acc * 10 + dig;
                end
                ee = bad || (acc >= 256);
                ed = 12'(acc % 256);
            end
            3'd4, 3'd5: begin
                for (int k = 0; k < DIGITS; k++) begin
                    dig = (int'(d) >> (4 * k)) & 15;
                    if (op == 3'd4) begin
                        if (dig > 9) bad = 1'b1;
                        ed = ed | 12'(((dig + 3) % 16) << (4 * k));
                    end else begin
                        if (dig < 3 || dig > 12) bad = 1'b1;
                        ed = ed | 12'(((dig + 13) % 16) << (4 * k));
                    end
                end
                ee = bad;
            end
            default: begin ed = 12'h000; ee = 1'b1; end
        endcase
        if (!ERR_EN) ee = 1'b0;
    endfunction

    task automatic do_req(input logic [2:0] op, input logic [3:0] tag,
                          input logic [11:0] data, input int hold, input string name);
        logic [11:0] ed;
        logic ee;
        int el, lat, waitc;
        model(op, data, ed, ee, el);
        waitc = 0;
        while (s_ready !== 1'b1 && waitc < 20) begin @(negedge clk); waitc++; end
        checks++;
        if (s_ready !== 1'b1) begin failures++; $display("FAIL %s ready_wait got=%b want=1", name, s_ready); end
        s_valid = 1'b1; s_op = op; s_tag = tag; s_data = data;
        @(negedge clk);
        s_valid = 1'b0; s_op = 3'($urandom); s_tag = 4'($urandom); s_data = 12'($urandom);
        checks++;
        if ({s_ready, busy} !== 2'b01) begin
            failures++; $display("FAIL %s busy_after_accept got=%b want=01", name, {s_ready, busy});
        end
        lat = 1;
        while (m_valid !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
        checks++;
        if (m_valid !== 1'b1) begin
            failures++; $display("FAIL %s timeout m_valid=%b want=1", name, m_valid);
            return;
        end
        checks++;
        if (lat != el) begin failures++; $display("FAIL %s latency got=%0d want=%0d", name, lat, el); end
        checks++;
        if (m_data !== ed) begin failures++; $display("FAIL %s data got=%h want=%h", name, m_data, ed); end
        checks++;
        if (m_tag !== tag) begin failures++; $display("FAIL %s tag got=%h want=%h", name, m_tag, tag); end
        checks++;
        if (m_err !== ee) begin failures++; $display("FAIL %s err got=%b want=%b", name, m_err, ee); end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checks++;
            if ({m_valid, m_data, m_tag, m_err, s_ready, done_cnt} !== {1'b1, ed, tag, ee, 1'b0, exp_cnt}) begin
                failures++;
                $display("FAIL %s hold%0d got v=%b d=%h t=%h e=%b r=%b c=%0d want v=1 d=%h t=%h e=%b r=0 c=%0d",
                         name, h, m_valid, m_data, m_tag, m_err, s_ready, done_cnt, ed, tag, ee, exp_cnt);
            end
        end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        if (exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
        checks++;
        if ({m_valid, s_ready, busy, done_cnt} !== {1'b0, 1'b1, 1'b0, exp_cnt}) begin
            failures++;
            $display("FAIL %s release got v=%b r=%b b=%b c=%0d want v=0 r=1 b=0 c=%0d",
                     name, m_valid, s_ready, busy, done_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0; s_op = 3'd0; s_tag = 4'd0; s_data = 12'h000;
        repeat (2) @(negedge clk);
        checks++;
        if ({s_ready, m_valid, m_data, m_tag, m_err, busy, done_cnt} !== {1'b1, 1'b0, 12'h000, 4'h0, 1'b0, 1'b0, 16'h0000}) begin
            failures++;
            $display("FAIL reset_state got r=%b v=%b d=%h t=%h e=%b b=%b c=%0d want r=1 v=0 d=000 t=0 e=0 b=0 c=0",
                     s_ready, m_valid, m_data, m_tag, m_err, busy, done_cnt);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({s_ready, m_valid, busy} !== 3'b100) begin
            failures++; $display("FAIL reset_release got=%b want=100", {s_ready, m_valid, busy});
        end
    endtask

    task automatic test_directed();
        do_req(3'd0, 4'd3, 12'h0B5, 0, "bin2gray_b5");
        do_req(3'd2, 4'd1, 12'h0FF, 0, "bin2bcd_ff");
        do_req(3'd6, 4'd2, 12'h0FF, 0, "bin2ex3_ff");
        do_req(3'd3, 4'd4, 12'h999, 0, "bcd2bin_999");
        do_req(3'd3, 4'd5, 12'h1A2, 0, "bcd2bin_1a2");
        do_req(3'd4, 4'd6, 12'h409, 0, "bcd2ex3_409");
        do_req(3'd5, 4'd7, 12'h3A3, 0, "ex32bcd_3a3");
        do_req(3'd5, 4'd8, 12'h3F3, 0, "ex32bcd_3f3");
        do_req(3'd7, 4'd9, 12'hABC, 0, "reserved_op");
        do_req(3'd1, 4'hA, 12'hF80, 0, "gray2bin_msb");
    endtask

    task automatic test_backpressure();
        do_req(3'd3, 4'hC, 12'h255, 5, "bp_bcd2bin");
        do_req(3'd0, 4'hD, 12'h1FF, 5, "bp_bin2gray");
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            do_req(3'($urandom_range(0, 7)), 4'($urandom), 12'($urandom), $urandom_range(0, 2), "random");
        end
    endtask

    task automatic test_reset_mid_conv();
        bit seen;
        s_valid = 1'b1; s_op = 3'd2; s_tag = 4'd5; s_data = 12'h0FF;
        @(negedge clk);
        s_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, m_valid} !== 2'b10) begin failures++; $display("FAIL midconv_busy got=%b want=10", {busy, m_valid}); end
        rst = 1'b1;
        #1;
        exp_cnt = '0;
        checks++;
        if ({s_ready, m_valid, m_data, m_tag, m_err, busy, done_cnt} !== {1'b1, 1'b0, 12'h000, 4'h0, 1'b0, 1'b0, 16'h0000}) begin
            failures++;
            $display("FAIL midconv_reset got r=%b v=%b d=%h t=%h e=%b b=%b c=%0d want r=1 v=0 d=000 t=0 e=0 b=0 c=0",
                     s_ready, m_valid, m_data, m_tag, m_err, busy, done_cnt);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (m_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin failures++; $display("FAIL midconv_no_result got m_valid=1 want=0"); end
        do_req(3'd2, 4'd9, 12'h0FF, 1, "after_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_mid_conv();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/code_converter_stream.md
Name: code_converter_stream

Overview:
Streaming, parametrised code-conversion engine with valid/ready handshakes on input and output, replacing the start/done converter top. Accepts one tagged request (opcode and operand) at a time and runs multi-cycle conversions on an internal iterative datapath. Returns the result with an error flag and an echoed tag. Sits between the command-decode front end and the result/display buffers.

Parameters:
WIDTH, 8, binary/Gray operand width in bits (>=2)
DIGITS, 3, number of BCD/excess-3 digits (>=1)
TAG_W, 4, width of the request tag echoed with the result
CNT_W, 16, width of the completed-request counter

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
s_valid  input  1  request valid
s_ready  output  1  request accepted when s_valid&&s_ready
s_op  input  3  opcode: 0 BIN2GRAY, 1 GRAY2BIN, 2 BIN2BCD, 3 BCD2BIN, 4 BCD2EX3, 5 EX32BCD, 6 BIN2EX3, 7 reserved
s_tag  input  TAG_W  request tag
s_data  input  DATA_W  operand, LSB-aligned; DATA_W = max(WIDTH, 4*DIGITS) (localparam)
m_valid  output  1  result valid
m_ready  input  1  result consumed when m_valid&&m_ready
m_data  output  DATA_W  result, LSB-aligned, zero-extended
m_tag  output  TAG_W  echoed s_tag
m_err  output  1  invalid digit / overflow / reserved opcode
busy  output  1  state != IDLE
done_cnt  output  CNT_W  count of results handed off; saturates at all-ones

Behaviour:
- Reset (async, active-high): state IDLE; s_ready=1; m_valid=0; m_data=0; m_tag=0; m_err=0; done_cnt=0; internal registers cleared. Reset mid-conversion aborts the request; no result is produced.
- FSM states: IDLE, CONV, OUT.
- IDLE: s_ready=1. On accept, latch op, tag and operand. Ops 0,1,4,5,7 go to OUT next cycle, with the result registered. Ops 2,3,6 go to CONV with iteration counter cleared.
- CONV: s_ready=0.
  - BIN2BCD and BIN2EX3: double-dabble over the low WIDTH bits. One bit per cycle, WIDTH cycles. BIN2EX3 adds 3 to every digit on the final cycle.
  - BCD2BIN: one digit per cycle, MS digit first; acc = acc*10 + digit; DIGITS cycles.
  - After the last iteration, go to OUT.
- OUT: m_valid=1. m_data, m_tag and m_err are stable while m_valid&&!m_ready.
  - On m_ready: done_cnt increments (saturating) and the FSM returns to IDLE.
  - No accept is possible in the OUT cycle (s_ready=0). One bubble cycle between requests.
- Latency from accept edge to m_valid:
  - 1 cycle for ops 0,1,4,5,7.
  - 1+WIDTH cycles for ops 2 and 6.
  - 1+DIGITS cycles for op 3.
- Arithmetic:
  - Gray conversion: gray = b ^ (b>>1) over WIDTH bits.
  - GRAY2BIN: prefix XOR from the MSB down.
  - Ex3 conversions are per-digit +3/−3 mod 16.
  - Upper unused bits of m_data are 0.
- Error rules (m_err=1, data still produced):
  - Any BCD input digit >9 (ops 3, 4).
  - Any ex3 input digit <3 or >12 (op 5).
  - BCD2BIN result ≥ 2^WIDTH; data is truncated mod 2^WIDTH.
  - BIN2BCD/BIN2EX3 value > 10^DIGITS−1; digits are truncated.
  - Opcode 7: m_data=0.
- Input bits above the operand's natural width are ignored.

Optional Feature:
CODE_CONV_ERR_CHECK_EN
- Defined: error rules as above.
- Undefined: all checks removed and m_err tied 0. Data results are unchanged, except opcode 7 still yields m_data=0.

Decomposition:
- Package code_conv_pkg holds:
  - op_e enum with 8 codes.
  - state_e (IDLE/CONV/OUT).
  - Constants BCD_DIGIT_MAX=9, EX3_OFFSET=3.
  - Function clog2 for the iteration-counter width.
- Sub-module code_conv_iter_unit: iterative double-dabble/BCD-accumulate engine with start/last handshake to the FSM.
- Single-cycle ops stay inline in the top.

Test Plan:
- Reset, then BIN2GRAY s_data=0xB5 tag=3 → one cycle later m_valid=1, m_data=0x0EF, m_tag=3, m_err=0, done_cnt=1 after handshake.
- BIN2BCD 0xFF → m_valid exactly 9 cycles after accept, m_data=0x255, m_err=0; BIN2EX3 0xFF → 0x588.
- BCD2BIN 0x999 → m_data=0x0E7, m_err=1 (overflow); BCD2BIN 0x1A2 → m_err=1 (invalid digit); both give m_err=0 with macro undefined.
- BCD2EX3 0x409 → 0x73C; EX32BCD 0x3A3 → 0x070, m_err=0; EX32BCD 0x3F3 → m_err=1.
- Backpressure: hold m_ready=0 for 5 cycles during OUT → m_data/m_tag/m_err stable, s_ready=0, done_cnt unchanged; release → IDLE next cycle.
- Assert rst mid-CONV of BIN2BCD → outputs and done_cnt go to reset values immediately, no m_valid. A new request after reset completes normally.
